// File: rtl/sgf_round_apply_if.sv
// Operand, decision-block and result signals of the significand rounding stage.
// The slave modport is the rounding stage; the master modport is its surroundings.
interface sgf_round_apply_if #(
    parameter int W_SGF = 23,
    parameter int W_EXP = 8,
    parameter int W_EXT = 3
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [W_SGF+W_EXT:0]     Sgf_i;
    logic [W_EXP-1:0]         Exp_i;
    logic                     Sign_i;
    logic [1:0]               Round_Type_i;
    logic [1:0]               Data_o;
    logic [1:0]               Round_Type_o;
    logic                     Sign_Result_o;
    logic                     Round_Flag_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [W_SGF-1:0]         Sgf_o;
    logic [W_EXP-1:0]         Exp_o;
    logic                     Sign_o;
    logic                     Ovf_o;

    modport slave (
        input  in_valid_i, Sgf_i, Exp_i, Sign_i, Round_Type_i, Round_Flag_i, out_ready_i,
        output in_ready_o, Data_o, Round_Type_o, Sign_Result_o,
               out_valid_o, Sgf_o, Exp_o, Sign_o, Ovf_o
    );

    modport master (
        output in_valid_i, Sgf_i, Exp_i, Sign_i, Round_Type_i, Round_Flag_i, out_ready_i,
        input  in_ready_o, Data_o, Round_Type_o, Sign_Result_o,
               out_valid_o, Sgf_o, Exp_o, Sign_o, Ovf_o
    );
endinterface

// File: rtl/sgf_round_apply.sv
// Significand rounding application: derives guard/sticky for the directed-rounding
// decision block, applies its round flag, renormalizes on carry and adjusts the exponent.
module sgf_round_apply #(
    parameter int W_SGF = 23,
    parameter int W_EXP = 8,
    parameter int W_EXT = 3
) (
    input logic             clk,
    input logic             rst_n,
    sgf_round_apply_if.slave io
);
    localparam int W_MAN = W_SGF + 1;
    localparam int W_SUM = W_SGF + 2;

    typedef enum logic [1:0] {IDLE, DEC, NORM, DONE} state_t;

    state_t state_q, state_d;

    logic [W_MAN-1:0] man_q, man_d;
    logic [W_EXP-1:0] exp_q, exp_d;
    logic             sign_q, sign_d;
    logic [1:0]       rtype_q, rtype_d;
    logic [1:0]       data_q, data_d;
    logic             special_q, special_d;
    logic [W_SUM-1:0] sum_q, sum_d;
    logic [W_SGF-1:0] sgf_res_q, sgf_res_d;
    logic [W_EXP-1:0] exp_res_q, exp_res_d;
    logic             sign_res_q, sign_res_d;
    logic             ovf_q, ovf_d;
    logic [W_EXP-1:0] exp_inc;
    logic             in_ready, out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (io.in_valid_i) state_d = DEC;
            DEC:  state_d = NORM;
            NORM: state_d = DONE;
            DONE: if (io.out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            man_q      <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            rtype_q    <= '0;
            data_q     <= '0;
            special_q  <= 1'b0;
            sum_q      <= '0;
            sgf_res_q  <= '0;
            exp_res_q  <= '0;
            sign_res_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            man_q      <= man_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            rtype_q    <= rtype_d;
            data_q     <= data_d;
            special_q  <= special_d;
            sum_q      <= sum_d;
            sgf_res_q  <= sgf_res_d;
            exp_res_q  <= exp_res_d;
            sign_res_q <= sign_res_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        man_d      = man_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        rtype_d    = rtype_q;
        data_d     = data_q;
        special_d  = special_q;
        sum_d      = sum_q;
        sgf_res_d  = sgf_res_q;
        exp_res_d  = exp_res_q;
        sign_res_d = sign_res_q;
        ovf_d      = ovf_q;
        exp_inc    = exp_q + W_EXP'(1);
        unique case (state_q)
            IDLE: if (io.in_valid_i) begin
                man_d     = io.Sgf_i[W_SGF+W_EXT:W_EXT];
                exp_d     = io.Exp_i;
                sign_d    = io.Sign_i;
                rtype_d   = (io.Round_Type_i == 2'b11) ? 2'b00 : io.Round_Type_i;
                special_d = &io.Exp_i;
                data_d    = special_d ? 2'b00
                                      : {io.Sgf_i[W_EXT-1], |io.Sgf_i[W_EXT-2:0]};
            end
            // Inf/NaN operands never take the increment, whatever the flag says.
            DEC: sum_d = W_SUM'(man_q) + W_SUM'(io.Round_Flag_i & ~special_q);
            NORM: begin
                sign_res_d = sign_q;
                ovf_d      = 1'b0;
                if (special_q) begin
                    sgf_res_d = man_q[W_SGF-1:0];
                    exp_res_d = exp_q;
                end else if (sum_q[W_SUM-1]) begin
                    if (&exp_inc) begin
                        sgf_res_d = '0;
                        exp_res_d = '1;
                        ovf_d     = 1'b1;
                    end else begin
                        sgf_res_d = sum_q[W_SGF:1];
                        exp_res_d = exp_inc;
                    end
                end else begin
                    sgf_res_d = sum_q[W_SGF-1:0];
                    exp_res_d = exp_q;
                end
            end
            DONE: if (io.out_ready_i) begin
                data_d     = '0;
                rtype_d    = '0;
                sign_d     = 1'b0;
                sgf_res_d  = '0;
                exp_res_d  = '0;
                sign_res_d = 1'b0;
                ovf_d      = 1'b0;
            end
            default: ;
        endcase
    end

    assign io.in_ready_o    = in_ready;
    assign io.out_valid_o   = out_valid;
    assign io.Data_o        = data_q;
    assign io.Round_Type_o  = rtype_q;
    assign io.Sign_Result_o = sign_q;
    assign io.Sgf_o         = sgf_res_q;
    assign io.Exp_o         = exp_res_q;
    assign io.Sign_o        = sign_res_q;
    assign io.Ovf_o         = ovf_q;
endmodule
